// File: rtl/result_collector.sv
// Captures controller results on the z/z_stable handshake into a small FIFO drained via valid/ready.
// Optional capture counter port total_cnt is enabled by defining RESULT_COLLECTOR_CNT_EN.
module result_collector #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in_z,
  input  logic                    in_z_stable,
  output logic                    out_z_ack,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  level
`ifdef RESULT_COLLECTOR_CNT_EN
  ,
  output logic [15:0]             total_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACK      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [AW:0] wr_ptr_reg, rd_ptr_reg;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic push, pop, empty;

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:     state_next = (in_z_stable && !full) ? ACK : IDLE;
      ACK:      state_next = WAIT_LOW;
      WAIT_LOW: state_next = in_z_stable ? WAIT_LOW : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    out_z_ack = (state_reg == ACK);
    push      = (state_reg == IDLE) && in_z_stable && !full;
  end

  // Status comes from registered pointers only, so a push is never visible the same cycle.
  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign rd_valid = !empty;
  assign level    = wr_ptr_reg - rd_ptr_reg;
  assign pop      = rd_valid && rd_ready;
  assign rd_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg[AW-1:0] == AW'(gi))) mem[gi] <= in_z;
      end
    end
  endgenerate

`ifdef RESULT_COLLECTOR_CNT_EN
  logic [15:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n)    cnt_reg <= '0;
    else if (push) cnt_reg <= cnt_reg + 16'd1;
  end

  assign total_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: stimulus queues expected read words, a forked monitor checks pops.
module tb_result_collector;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_z;
  logic        in_z_stable;
  logic        out_z_ack;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        full;
  logic [2:0]  level;
`ifdef RESULT_COLLECTOR_CNT_EN
  logic [15:0] total_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] sb [$];

  result_collector #(.DATA_WIDTH(64), .DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_z(in_z),
    .in_z_stable(in_z_stable),
    .out_z_ack(out_z_ack),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .full(full),
    .level(level)
`ifdef RESULT_COLLECTOR_CNT_EN
    ,
    .total_cnt(total_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Present one result, expect capture on the next edge, then release the handshake.
  task automatic send(input logic [63:0] v);
    int cyc;
    in_z = v;
    in_z_stable = 1'b1;
    sb.push_back(v);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!out_z_ack && cyc < 20);
    check("ack_latency", 64'(cyc), 64'd1);
    in_z_stable = 1'b0;
    tick();
    check("ack_one_cycle", {63'd0, out_z_ack}, 64'd0);
    tick();
  endtask

  task automatic pop_n(input int n);
    rd_ready = 1'b1;
    repeat (n) tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    int acks;
    rst_n = 1'b0;
    in_z = '0;
    in_z_stable = 1'b0;
    rd_ready = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && rd_valid && rd_ready) begin
          if (sb.size() == 0) check("pop_unexpected", rd_data, 64'hDEAD);
          else check("pop_data", rd_data, sb.pop_front());
        end
      end
    join_none

    tick();
    tick();
    check("rst_ack", {63'd0, out_z_ack}, 64'd0);
    check("rst_valid", {63'd0, rd_valid}, 64'd0);
    check("rst_full", {63'd0, full}, 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_data", rd_data, 64'd0);
    rst_n = 1'b1;
    tick();

    // Single result, then drain
    send(64'h3FF0_0000_0000_0000);
    check("t1_valid", {63'd0, rd_valid}, 64'd1);
    check("t1_level", 64'(level), 64'd1);
    check("t1_data", rd_data, 64'h3FF0_0000_0000_0000);
    pop_n(1);
    check("t1_level_after_pop", 64'(level), 64'd0);
    check("t1_data_empty", rd_data, 64'd0);

    // Stable held high for six cycles: one capture only
    in_z = 64'hA;
    in_z_stable = 1'b1;
    sb.push_back(64'hA);
    acks = 0;
    repeat (6) begin
      tick();
      if (out_z_ack) acks++;
    end
    check("t2_ack_count", 64'(acks), 64'd1);
    check("t2_level", 64'(level), 64'd1);
    in_z_stable = 1'b0;
    tick();
    tick();
    pop_n(1);
    check("t2_level_drained", 64'(level), 64'd0);

    // Fill to full, fifth result held off until a pop frees space
    for (int i = 1; i <= 4; i++) send(64'(i));
    check("t3_full", {63'd0, full}, 64'd1);
    check("t3_level4", 64'(level), 64'd4);
    in_z = 64'd5;
    in_z_stable = 1'b1;
    sb.push_back(64'd5);
    acks = 0;
    repeat (3) begin
      tick();
      if (out_z_ack) acks++;
    end
    check("t3_blocked_acks", 64'(acks), 64'd0);
    check("t3_blocked_level", 64'(level), 64'd4);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("t3_pop_level", 64'(level), 64'd3);
    check("t3_pop_full", {63'd0, full}, 64'd0);
    check("t3_pop_noack", {63'd0, out_z_ack}, 64'd0);
    tick();
    check("t3_late_ack", {63'd0, out_z_ack}, 64'd1);
    check("t3_late_level", 64'(level), 64'd4);
    in_z_stable = 1'b0;
    pop_n(4);
    check("t3_drained", 64'(level), 64'd0);

    // Push and pop on the same edge at level 2
    send(64'd11);
    send(64'd12);
    in_z = 64'd13;
    in_z_stable = 1'b1;
    sb.push_back(64'd13);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("t4_level_same", 64'(level), 64'd2);
    check("t4_ack", {63'd0, out_z_ack}, 64'd1);
    in_z_stable = 1'b0;
    tick();
    tick();
    pop_n(2);
    check("t4_drained", 64'(level), 64'd0);

    // Ten results with the consumer always ready, crossing pointer wrap
    rd_ready = 1'b1;
    for (int i = 1; i <= 10; i++) send(64'(i));
    tick();
    rd_ready = 1'b0;
    check("t4_stream_level", 64'(level), 64'd0);
    check("t4_stream_sb", 64'(sb.size()), 64'd0);

    // Reset while acknowledging with three entries buffered
    send(64'd21);
    send(64'd22);
    in_z = 64'd23;
    in_z_stable = 1'b1;
    tick();
    check("t5_pre_ack", {63'd0, out_z_ack}, 64'd1);
    check("t5_pre_level", 64'(level), 64'd3);
    rst_n = 1'b0;
    in_z_stable = 1'b0;
    tick();
    check("t5_rst_ack", {63'd0, out_z_ack}, 64'd0);
    check("t5_rst_level", 64'(level), 64'd0);
    check("t5_rst_valid", {63'd0, rd_valid}, 64'd0);
    sb.delete();
    rst_n = 1'b1;
    tick();
    send(64'h7);
    check("t5_readback", rd_data, 64'h7);
    check("t5_level", 64'(level), 64'd1);
    pop_n(1);

`ifdef RESULT_COLLECTOR_CNT_EN
    rd_ready = 1'b1;
    for (int i = 8; i <= 11; i++) send(64'(i));
    check("cnt_five", 64'(total_cnt), 64'd5);
    force dut.cnt_reg = 16'hFFFF;
    tick();
    release dut.cnt_reg;
    send(64'd99);
    check("cnt_wrap", 64'(total_cnt), 64'd0);
    tick();
    rd_ready = 1'b0;
`endif

    tick();
    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("final_level", 64'(level), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
